// File: rtl/rr_encoder_pkg.sv
// Shared mode encodings and index-width helper for rr_encoder and rr_pick.
package rr_encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A single request line still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational pick of one active request: lowest set bit, or the first set bit at/after start with wrap.
module rr_pick
  import rr_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0]   eff;
  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  logic           hit;

  // Upper half is the unmasked vector, so a scan that falls off the masked half wraps to index 0.
  always_comb begin
    eff    = (mode == MODE_RR) ? start : '0;
    masked = '0;
    for (int i = 0; i < N; i++)
      masked[i] = req[i] && (i >= int'(eff));
    dbl    = {req, masked};
    found  = |req;
    winner = '0;
    hit    = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (!hit && dbl[i]) begin
        hit    = 1'b1;
        winner = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Registered priority encoder with valid/ready output and fixed-priority or round-robin selection.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] ptr
);

  logic         found;
  logic [W-1:0] winner;
  logic         cap;

  rr_pick #(.N(N), .W(W)) u_pick (
    .req    (req),
    .start  (ptr),
    .mode   (mode),
    .found  (found),
    .winner (winner)
  );

  // A free slot or a same-cycle consume both open the register for a new result.
  assign cap = enable && found && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else if (cap) begin
      out_valid  <= 1'b1;
      out_idx    <= winner;
      out_onehot <= N'(1) << winner;
      if (mode == MODE_RR)
        ptr <= (winner == W'(N - 1)) ? '0 : winner + W'(1);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end
  end

endmodule

// File: tb/tb_rr_encoder.sv
// Bench for rr_encoder: N=8 and N=5 instances against a scan-by-offset reference model.
module tb_rr_encoder;
  import rr_encoder_pkg::*;

  localparam int W8 = idx_width(8);
  localparam int W5 = idx_width(5);

  logic clk = 1'b0;
  logic rst, enable, mode, out_ready;
  logic [7:0] req8;
  logic [4:0] req5;

  logic          vld8, vld5;
  logic [W8-1:0] idx8, ptr8;
  logic [W5-1:0] idx5, ptr5;
  logic [7:0]    oh8;
  logic [4:0]    oh5;

  int n_chk  = 0;
  int n_pass = 0;

  int m_vld [2];
  int m_idx [2];
  int m_ptr [2];
  int m_n   [2] = '{8, 5};

  always #5 clk = ~clk;

  rr_encoder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .req(req8),
    .out_ready(out_ready), .out_valid(vld8), .out_idx(idx8),
    .out_onehot(oh8), .ptr(ptr8)
  );

  rr_encoder #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .req(req5),
    .out_ready(out_ready), .out_valid(vld5), .out_idx(idx5),
    .out_onehot(oh5), .ptr(ptr5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Walk n positions starting from the pointer (or 0), return first active line.
  function automatic int pick(input logic [7:0] r, input int n, input int p, input logic m);
    int s = m ? p : 0;
    for (int k = 0; k < n; k++) begin
      int i = (s + k) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] r = (d == 0) ? req8 : {3'b0, req5};
      int w;
      if (rst) begin
        m_vld[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
      end else begin
        w = pick(r, m_n[d], m_ptr[d], mode);
        if (enable && w >= 0 && (m_vld[d] == 0 || out_ready)) begin
          m_vld[d] = 1;
          m_idx[d] = w;
          if (mode) m_ptr[d] = (w + 1) % m_n[d];
        end else if (m_vld[d] != 0 && out_ready) begin
          m_vld[d] = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("vld8", 32'(vld8), 32'(m_vld[0]));
    chk("idx8", 32'(idx8), 32'(m_idx[0]));
    chk("oh8",  32'(oh8),  m_vld[0] != 0 ? 32'(1) << m_idx[0] : 32'd0);
    chk("ptr8", 32'(ptr8), 32'(m_ptr[0]));
    chk("vld5", 32'(vld5), 32'(m_vld[1]));
    chk("idx5", 32'(idx5), 32'(m_idx[1]));
    chk("oh5",  32'(oh5),  m_vld[1] != 0 ? 32'(1) << m_idx[1] : 32'd0);
    chk("ptr5", 32'(ptr5), 32'(m_ptr[1]));
  endtask

  initial begin
    m_vld = '{0, 0}; m_idx = '{0, 0}; m_ptr = '{0, 0};
    rst = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b0;
    req8 = 8'hFF; req5 = 5'h1F;
    @(negedge clk);

    // reset with all requests high
    repeat (2) step();
    chk("rst_vld", 32'(vld8), 32'd0);
    chk("rst_ptr", 32'(ptr8), 32'd0);

    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("first_idx", 32'(idx8), 32'd0);

    // fixed priority
    req8 = 8'b1010_0100; req5 = 5'b10100;
    repeat (4) step();
    chk("fixed_idx", 32'(idx8), 32'd2);
    chk("fixed_oh",  32'(oh8),  32'h04);

    // round-robin sweep, N=5 alternates 0/4
    mode = 1'b1; req8 = 8'hFF; req5 = 5'b10001;
    repeat (9) step();
    chk("sweep_wrap_ptr", 32'(ptr8), 32'd1);

    // backpressure
    req8 = 8'b1000_0010;
    step();
    chk("bp_idx", 32'(idx8), 32'd1);
    out_ready = 1'b0;
    repeat (4) step();
    chk("bp_hold_ptr", 32'(ptr8), 32'd2);
    out_ready = 1'b1;
    repeat (2) step();

    // enable low: drain only
    enable = 1'b0; req8 = 8'h10; out_ready = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (2) step();
    chk("en_drain", 32'(vld8), 32'd0);

    // empty requests
    enable = 1'b1; req8 = 8'h00; req5 = 5'h00;
    repeat (2) step();

    // mid-run reset
    req8 = 8'hFF; req5 = 5'b10001;
    repeat (3) step();
    rst = 1'b1; step();
    chk("midrst_ptr5", 32'(ptr5), 32'd0);
    rst = 1'b0;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      req8      = 8'($urandom) & 8'($urandom);
      req5      = 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_encoder.md
# rr_encoder

Parametrised N-input priority encoder with registered output, a valid/ready output handshake and a selectable fixed-priority or round-robin mode. Each accepted cycle picks one active request line and presents it as both a binary index and a one-hot vector. It sits between request sources (interrupt lines, channel-busy flags) and a single consumer that services one index at a time. It is the sequential, arbitrating successor to the team's 3-to-8 one-hot decoder with enable.

## Interface

- N, default 8: number of request lines; legal range 1..256.
- W, derived as max(1, clog2(N)); not overridable: width of the index output.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new capture; a held result still drains.
- mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- req  input  N  level-sensitive request lines, bit i = request i.
- out_ready  input  1  consumer accepts the current result this cycle.
- out_valid  output  1  out_idx/out_onehot hold a valid result.
- out_idx  output  W  binary index of the selected request.
- out_onehot  output  N  one-hot of out_idx; all zero when out_valid = 0.
- ptr  output  W  current round-robin start pointer, for debug and verification.

## Operation

- Capture condition: cap = enable & |req & (!out_valid | out_ready).
- Winner selection:
  - mode 0: lowest set bit of req.
  - mode 1: first set bit at or above ptr, scanning upward and wrapping from N-1 to 0.
- On cap:
  - out_valid <= 1.
  - out_idx <= winner.
  - out_onehot <= 1 << winner.
  - In mode 1 only, ptr <= (winner == N-1) ? 0 : winner+1.
  - ptr is unchanged in mode 0.
- On out_valid & out_ready & !cap: out_valid <= 0 and out_onehot <= 0. out_idx keeps its last value.
- On out_valid & !out_ready: all outputs are held stable. req changes are ignored until the slot frees.
- Requests are not latched. A line that drops before capture is simply not selected.
- enable low:
  - cap is forced to 0.
  - A pending result still completes its handshake.
  - ptr holds.
- mode is sampled only at capture. Changing mode while a result is held has no effect on that result.
- Non-power-of-2 N: ptr and out_idx never exceed N-1.
- N = 1: out_idx and ptr are tied to 0, and the block degenerates to a registered valid/ready on req[0].

## Timing

- Reset (rst = 1 at a clock edge) sets out_valid = 0, out_idx = 0, out_onehot = 0, ptr = 0. Reset overrides cap and the handshake in the same cycle.
- Reset mid-handshake drops the held result without it being consumed.
- Latency: req is sampled at edge k; the result is visible after edge k; out_valid = 1 during cycle k+1.
- Throughput: one result per cycle while out_ready = 1 and requests are present, i.e. back-to-back capture on consume.
- Simultaneous consume and capture in one cycle: the new result replaces the old one and out_valid stays 1 (no bubble).
- out_ready while out_valid = 0 is ignored.
- No combinational path from any input to any output. All outputs come straight from registers.

## Structure

- Package rr_encoder_pkg contains:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function idx_width(N) returning max(1, clog2(N)).
- Sub-module rr_pick: combinational. Inputs are req, start index and mode; outputs are found and winner index.
  - Implemented as a double-width masked priority scan.
  - Reused by the future arbiter blocks.
- The top level contains only the capture/handshake register stage and the ptr register.

## Test plan

- Reset: assert rst with req = 8'hFF for 2 cycles -> out_valid = 0, out_onehot = 0, ptr = 0. First result after release is idx 0.
- Fixed priority: mode = 0, req = 8'b1010_0100, out_ready = 1 held -> idx 2 every cycle, onehot 8'h04, ptr stays 0.
- Round-robin sweep: mode = 1, req = 8'hFF, out_ready = 1 -> idx 0,1,...,7,0 on consecutive cycles; ptr wraps 7 -> 0.
- Backpressure: mode = 1, req = 8'b1000_0010, out_ready = 0 for 4 cycles -> idx 1 held stable with ptr = 2. Raise out_ready -> next result is idx 7, then idx 1.
- enable and empty: enable = 0 with req = 8'h10 -> no capture. Held result drains on out_ready, then out_valid = 0. req = 0 with enable = 1 -> out_valid falls after consume.
- Non-power-of-2: N = 5, mode = 1, req = 5'b10001 -> idx 0,4,0,4; ptr never exceeds 4. Also mid-run rst -> ptr returns to 0.
